// File: rtl/mem_arbiter_if.sv
// Bundle of the core I/D request ports, the memory bus and the error strobe.
// The arbiter connects through the slave modport; the core/memory side uses master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;

  logic              d_req;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_cen;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;

  logic              err;

  modport slave (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata, mem_stall,
    output i_rdata, i_ready, d_rdata, d_ready,
    output mem_cen, mem_wen, mem_addr, mem_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata, mem_stall,
    input  i_rdata, i_ready, d_rdata, d_ready,
    input  mem_cen, mem_wen, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch (I) and
// data (D) ports, with a stall watchdog that aborts hung transactions.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state,       state_n;
  logic              owner_d,     owner_n;
  logic              last_d,      last_n;
  logic [CNT_W-1:0]  cnt,         cnt_n;
  logic [DATA_W-1:0] i_rdata_q,   i_rdata_n;
  logic              i_ready_q,   i_ready_n;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_n;
  logic              d_ready_q,   d_ready_n;
  logic              mem_cen_q,   mem_cen_n;
  logic              mem_wen_q,   mem_wen_n;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_n;
  logic              err_q,       err_n;

  logic              grant_d;
  logic              finish;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] rd_val;

  assign cnt_inc = cnt + CNT_W'(1);

  always_comb begin
    state_n     = state;
    owner_n     = owner_d;
    last_n      = last_d;
    cnt_n       = cnt;
    i_rdata_n   = i_rdata_q;
    d_rdata_n   = d_rdata_q;
    i_ready_n   = 1'b0;
    d_ready_n   = 1'b0;
    err_n       = 1'b0;
    mem_cen_n   = 1'b0;
    mem_wen_n   = mem_wen_q;
    mem_addr_n  = mem_addr_q;
    mem_wdata_n = mem_wdata_q;
    grant_d     = 1'b0;
    finish      = 1'b0;
    rd_val      = '0;

    case (state)
      IDLE: begin
        // D wins when it is the only requester or when I was served last.
        grant_d = bus.d_req & (~bus.i_req | ~last_d);
        if (bus.i_req | bus.d_req) begin
          mem_cen_n   = 1'b1;
          mem_addr_n  = grant_d ? bus.d_addr : bus.i_addr;
          mem_wen_n   = grant_d & bus.d_wen;
          mem_wdata_n = grant_d ? bus.d_wdata : '0;
          owner_n     = grant_d;
          last_n      = grant_d;
          cnt_n       = '0;
          state_n     = WAIT;
        end
      end

      WAIT: begin
        if (!bus.mem_stall) begin
          finish = 1'b1;
          rd_val = bus.mem_rdata;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          finish = 1'b1;
          err_n  = 1'b1;
          rd_val = '0;
        end else begin
          cnt_n = cnt_inc;
        end

        if (finish) begin
          if (owner_d) begin
            d_ready_n = 1'b1;
            if (!mem_wen_q) begin
              d_rdata_n = rd_val;
            end
          end else begin
            i_ready_n = 1'b1;
            i_rdata_n = rd_val;
          end
          mem_wen_n   = 1'b0;
          mem_addr_n  = '0;
          mem_wdata_n = '0;
          state_n     = RESP;
        end
      end

      RESP: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      last_d      <= 1'b1;
      cnt         <= '0;
      i_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
      mem_cen_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      owner_d     <= owner_n;
      last_d      <= last_n;
      cnt         <= cnt_n;
      i_rdata_q   <= i_rdata_n;
      i_ready_q   <= i_ready_n;
      d_rdata_q   <= d_rdata_n;
      d_ready_q   <= d_ready_n;
      mem_cen_q   <= mem_cen_n;
      mem_wen_q   <= mem_wen_n;
      mem_addr_q  <= mem_addr_n;
      mem_wdata_q <= mem_wdata_n;
      err_q       <= err_n;
    end
  end

  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_ready   = i_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.mem_cen   = mem_cen_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.err       = err_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported memory between the core's instruction-fetch port and its data port.
- Arbitrates round-robin, registers the winning request onto the memory bus, and waits out memory stalls. Returns read data with a one-cycle ready pulse.
- Includes a stall watchdog that aborts hung transactions and flags an error.
- Sits between the core's I/D interfaces and a unified memory model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max stall cycles in WAIT before abort (1..2^CNT_W-1)
CNT_W, 8, watchdog counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
i_req  input  1  fetch request; hold with i_addr until i_ready
i_addr  input  ADDR_W  fetch address
i_rdata  output  DATA_W  fetch data, valid while i_ready
i_ready  output  1  one-cycle completion pulse for fetch
d_req  input  1  data request; hold with payload until d_ready
d_wen  input  1  1 = write, 0 = read
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  write data
d_rdata  output  DATA_W  read data, valid while d_ready after a read
d_ready  output  1  one-cycle completion pulse for data
mem_cen  output  1  one-cycle request strobe to memory
mem_wen  output  1  write enable to memory
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid in completion cycle
mem_stall  input  1  memory busy; completion = first WAIT cycle with mem_stall=0
err  output  1  one-cycle pulse on watchdog abort

Behaviour:
Interface:
- One clock; reset is asynchronous and active-low, ports named clk and rst_n.
- All outputs are registered.

Reset:
- state=IDLE; last_grant=D, so the first tie goes to I.
- All outputs 0; watchdog counter 0.
- Reset asserted mid-transaction drops the transaction immediately: no ready, no err, mem_cen=0.

States: IDLE, WAIT, RESP.

IDLE:
- If no request, stay.
- If one request, grant it. If both, grant the port that is not last_grant.
- On the grant edge:
  - mem_cen<=1, mem_addr<=addr.
  - For D: mem_wen<=d_wen, mem_wdata<=d_wdata.
  - For I: mem_wen<=0, mem_wdata<=0.
  - owner<=grantee, last_grant<=grantee, counter<=0, state<=WAIT.
- Payload is sampled only at the grant edge; later changes are ignored.

WAIT:
- mem_cen is high only in the first WAIT cycle; mem_wen, mem_addr and mem_wdata stay stable until leaving WAIT.
- If mem_stall=0, the transaction completes:
  - Owner ready<=1.
  - On a read, owner rdata<=mem_rdata.
  - On a write, d_rdata keeps its old value.
  - state<=RESP.
- If mem_stall=1: counter++. When counter reaches TIMEOUT, abort:
  - err<=1 and owner ready<=1.
  - Owner rdata<=0 on a read.
  - state<=RESP.
- mem_wen, mem_addr and mem_wdata clear to 0 on exit.

RESP:
- Ready (and err, if set) is high for exactly this cycle.
- Next edge: ready<=0, err<=0, state<=IDLE.
- Requests are not sampled in RESP, so a req held through the ready cycle is seen as a new request in the following IDLE.

Latency:
- Zero-stall access: req first sampled in cycle T, mem_cen in T+1, ready in T+2.
- Per-port throughput: one transaction every 3 cycles; with stalls, +1 cycle per stall cycle.

Other rules:
- i_ready and d_ready are never high together.
- A port that drops req before its ready still has its transaction completed and ready pulsed; this is a protocol violation but harmless.
- Round-robin prevents starvation: under continuous dual requests, grants alternate I, D, I, D.
- Rdata outputs hold their last value outside ready pulses.

Test Plan:
- Reset, then i_req=1 with i_addr=0x10, mem_stall=0, mem_rdata=0x00000013 -> mem_cen pulse with mem_addr=0x10, mem_wen=0 one cycle after req; i_ready=1 with i_rdata=0x13 two cycles after req.
- d_req=1, d_wen=1, d_addr=0x40, d_wdata=0xDEADBEEF, mem_stall high 3 cycles -> mem_wen/addr/wdata held 4 WAIT cycles; d_ready 5 cycles after req; d_rdata unchanged.
- i_req and d_req both held continuously after reset, zero stall -> grant order I, D, I, D; each ready 3 cycles apart; never both ready at once.
- TIMEOUT=4, d read with mem_stall stuck at 1 -> abort after 4 stall cycles: err=1, d_ready=1, d_rdata=0 for one cycle; then IDLE, next request served normally.
- rst_n pulled low during WAIT of an I read -> all outputs 0 immediately, no i_ready; after release, a pending d_req wins if it arrives first, otherwise I wins the first tie.
